// File: rtl/lenet_pkg.sv
// Shared definitions for the lenet DRAM streaming blocks: FSM state
// encoding, default bus widths and a counter-width helper.
package lenet_pkg;

    localparam int unsigned LENET_DATA_WIDTH = 32;
    localparam int unsigned LENET_ADDR_WIDTH = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } rd_state_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever the FIFO is non-empty and reads as zero when empty.
// Push and pop may coincide at any occupancy; a push into a full FIFO is
// only taken when a pop frees a slot in the same cycle.
module sync_fifo_fwft
    import lenet_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 8,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign count    = cnt_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dram_rd_stream.sv
// Read-side streaming front end between the DRAM model and the lenet
// datapath. One burst command issues sequential word reads; returned words
// are buffered in a FWFT FIFO and handed to the consumer over valid/ready.
// Reads are credit-limited so in-flight reads plus buffered words never
// exceed the FIFO depth, independent of DRAM return latency.
module dram_rd_stream
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LENET_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = LENET_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data_rd,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  delivered_q, delivered_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  fifo_push;
    logic                  fifo_empty;
    logic                  unused_fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic [SUM_W-1:0]      credit_sum;
    logic                  credit_ok;
    logic                  issue;
    logic                  out_xfer;

    // Returns are only meaningful inside a burst; stray ones are dropped.
    assign fifo_push = dram_valid && (state_q == ST_RUN);
    assign out_vld   = !fifo_empty;
    assign out_xfer  = out_vld && out_rdy;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (dram_data_rd),
        .pop       (out_rdy),
        .pop_data  (out_data),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credit check: reads in flight plus buffered words must stay below DEPTH.
    // A read decided this cycle is already counted in outstanding next cycle.
    always_comb begin
        credit_sum = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
        credit_ok  = credit_sum < SUM_W'(DEPTH);
    end

    // Burst sequencing: accept, issue/return/deliver accounting, completion.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        issued_d      = issued_q;
        delivered_d   = delivered_q;
        outstanding_d = outstanding_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        issue         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    base_d        = cmd_addr;
                    len_d         = cmd_len;
                    issued_d      = '0;
                    delivered_d   = '0;
                    outstanding_d = '0;
                    busy_d        = 1'b1;
                    if (cmd_len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        // The first read is issued on accept so its strobe
                        // lands in the cycle right after the handshake.
                        state_d       = ST_RUN;
                        rd_en_d       = 1'b1;
                        rd_addr_d     = cmd_addr;
                        issued_d      = LEN_WIDTH'(1);
                        outstanding_d = CNT_W'(1);
                    end
                end
            end

            ST_RUN: begin
                issue = (issued_q < len_q) && credit_ok;
                if (issue) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + ADDR_WIDTH'(issued_q);
                    issued_d  = issued_q + LEN_WIDTH'(1);
                end
                // Issue, return and pop can all occur together; net update.
                outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(fifo_push);
                delivered_d   = delivered_q + LEN_WIDTH'(out_xfer);
                if (delivered_d == len_q) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            delivered_q   <= delivered_d;
            outstanding_q <= outstanding_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // cmd_rdy is held low while reset is asserted so every output reads zero.
    assign cmd_rdy      = (state_q == ST_IDLE) && !rst;
    assign dram_en_rd   = rd_en_q;
    assign dram_addr_rd = rd_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
